// File: rtl/hazard_unit_pkg.sv
// Shared pipeline constants for the hazard/forwarding controller.
//   FWD_*    : ALU operand mux select encodings
//   REG_ZERO : hard-wired zero register, never a hazard or forward source
//   REGA_W   : register-index width
//   fwd_select() : operand forward choice from the M/W shadow fields
package pipe_pkg;

   localparam int REGA_W = 5;
   localparam logic [REGA_W-1:0] REG_ZERO = 5'd0;

   typedef logic [1:0] fwd_sel_t;

   localparam fwd_sel_t FWD_RF = 2'b00;
   localparam fwd_sel_t FWD_W  = 2'b01;
   localparam fwd_sel_t FWD_M  = 2'b10;

   // A load sitting in M has no data yet, so it cannot be forwarded from M;
   // the check falls through to W.
   function automatic fwd_sel_t fwd_select(
      input logic [REGA_W-1:0] src,
      input logic [REGA_W-1:0] wr_m,
      input logic              we_m,
      input logic              ld_m,
      input logic [REGA_W-1:0] wr_w,
      input logic              we_w
   );
      if (we_m && (wr_m != REG_ZERO) && (wr_m == src) && !ld_m)
         return FWD_M;
      else if (we_w && (wr_w != REG_ZERO) && (wr_w == src))
         return FWD_W;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the pipeline datapath and the hazard unit.
//   master : pipeline side (drives D/E fields, receives stall/flush/forward)
//   slave  : hazard unit side
//   CNT_W  : width of the stall/flush event counters
interface hazard_unit_if #(parameter int CNT_W = 16);
   import pipe_pkg::*;

   logic [REGA_W-1:0] rsD;
   logic [REGA_W-1:0] rtD;
   logic [REGA_W-1:0] rsE;
   logic [REGA_W-1:0] rtE;
   logic [REGA_W-1:0] writeregE;
   logic              rfweE;
   logic              mtorfselE;
   logic              branchtakenE;

   logic              stallF;
   logic              stallD;
   logic              flushD;
   logic              flushE;
   logic [1:0]        fwdAE;
   logic [1:0]        fwdBE;
   logic [CNT_W-1:0]  stallcnt;
   logic [CNT_W-1:0]  flushcnt;

   modport master (
      output rsD, rtD, rsE, rtE, writeregE, rfweE, mtorfselE, branchtakenE,
      input  stallF, stallD, flushD, flushE, fwdAE, fwdBE, stallcnt, flushcnt
   );

   modport slave (
      input  rsD, rtD, rsE, rtE, writeregE, rfweE, mtorfselE, branchtakenE,
      output stallF, stallD, flushD, flushE, fwdAE, fwdBE, stallcnt, flushcnt
   );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter for performance-debug event counts.
//   clk, rst : clock, async active-high reset (clears count)
//   inc      : count one event on this edge
//   count    : current value, holds at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller beside the D-to-E pipeline register.
// Keeps shadow copies of the M/W write-back fields, detects load-use and
// taken-branch hazards, and selects E-stage ALU operand forwarding.
//   clk, rst : clock, async active-high reset
//   hz       : slave side of hazard_unit_if (D/E fields in, stall/flush,
//              forward selects and event counters out)
module hazard_unit
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic         clk,
   input  logic         rst,
   hazard_unit_if.slave hz
);

   logic [REGA_W-1:0] writeregM;
   logic              rfweM;
   logic              mtorfselM;
   logic [REGA_W-1:0] writeregW;
   logic              rfweW;

   logic              lduse;
   logic              brflush;
   logic              stall_evt;
   logic [CNT_W-1:0]  stallcnt_q;
   logic [CNT_W-1:0]  flushcnt_q;

   // Writes to r0 are dropped on entry so they can never match later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         writeregM <= REG_ZERO;
         rfweM     <= 1'b0;
         mtorfselM <= 1'b0;
         writeregW <= REG_ZERO;
         rfweW     <= 1'b0;
      end else begin
         writeregM <= hz.writeregE;
         rfweM     <= hz.rfweE & (hz.writeregE != REG_ZERO);
         mtorfselM <= hz.mtorfselE;
         writeregW <= writeregM;
         rfweW     <= rfweM;
      end
   end

   assign lduse = hz.mtorfselE & hz.rfweE & (hz.writeregE != REG_ZERO) &
                  ((hz.writeregE == hz.rsD) | (hz.writeregE == hz.rtD));
   assign brflush = hz.branchtakenE;

   // A taken branch makes the D instruction wrong-path, so its flush
   // overrides any load-use stall.
   always_comb begin
      hz.stallF = 1'b0;
      hz.stallD = 1'b0;
      hz.flushD = 1'b0;
      hz.flushE = 1'b0;
      if (brflush) begin
         hz.flushD = 1'b1;
         hz.flushE = 1'b1;
      end else if (lduse) begin
         hz.stallF = 1'b1;
         hz.stallD = 1'b1;
         hz.flushE = 1'b1;
      end
   end

   assign hz.fwdAE = fwd_select(hz.rsE, writeregM, rfweM, mtorfselM, writeregW, rfweW);
   assign hz.fwdBE = fwd_select(hz.rtE, writeregM, rfweM, mtorfselM, writeregW, rfweW);

   assign stall_evt = lduse & ~brflush;

   sat_counter #(.W(CNT_W)) u_stallcnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_evt),
      .count (stallcnt_q)
   );

   sat_counter #(.W(CNT_W)) u_flushcnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (brflush),
      .count (flushcnt_q)
   );

   assign hz.stallcnt = stallcnt_q;
   assign hz.flushcnt = flushcnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   hazard_unit_if #(.CNT_W(CNT_W)) hz ();

   hazard_unit #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   // Reference model: history of instructions that have left E,
   // index 0 = one edge ago (M), index 1 = two edges ago (W).
   typedef struct {
      int wr;
      bit we;
      bit ld;
   } ent_t;

   ent_t hist[$];
   int   scnt;
   int   fcnt;

   int tests = 0;
   int fails = 0;

   logic [1:0] obs_fwdA, obs_fwdB;
   logic       obs_stallF, obs_stallD, obs_flushD, obs_flushE;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_fwd(input int src);
      ent_t m = hist[0];
      ent_t w = hist[1];
      if (src == 0) return 0;
      if (m.we && m.wr == src && !m.ld) return 2;
      if (w.we && w.wr == src) return 1;
      return 0;
   endfunction

   function automatic void model_reset();
      ent_t z = '{wr: 0, we: 1'b0, ld: 1'b0};
      hist.delete();
      hist.push_back(z);
      hist.push_back(z);
      scnt = 0;
      fcnt = 0;
   endfunction

   task automatic drive(input int rsd, input int rtd, input int rse, input int rte,
                        input int wr, input bit we, input bit ld, input bit bt);
      hz.rsD          = 5'(rsd);
      hz.rtD          = 5'(rtd);
      hz.rsE          = 5'(rse);
      hz.rtE          = 5'(rte);
      hz.writeregE    = 5'(wr);
      hz.rfweE        = we;
      hz.mtorfselE    = ld;
      hz.branchtakenE = bt;
   endtask

   // One pipeline cycle: check combinational outputs, clock, check counters.
   task automatic step(input int rsd, input int rtd, input int rse, input int rte,
                       input int wr, input bit we, input bit ld, input bit bt);
      bit lu;
      drive(rsd, rtd, rse, rte, wr, we, ld, bt);
      #2;
      lu = ld && we && (wr != 0) && (wr == rsd || wr == rtd);
      obs_fwdA   = hz.fwdAE;
      obs_fwdB   = hz.fwdBE;
      obs_stallF = hz.stallF;
      obs_stallD = hz.stallD;
      obs_flushD = hz.flushD;
      obs_flushE = hz.flushE;
      chk("flushD", 32'(obs_flushD), 32'(bt));
      chk("flushE", 32'(obs_flushE), 32'(bt || lu));
      chk("stallF", 32'(obs_stallF), 32'(!bt && lu));
      chk("stallD", 32'(obs_stallD), 32'(!bt && lu));
      chk("fwdAE", 32'(obs_fwdA), 32'(model_fwd(rse)));
      chk("fwdBE", 32'(obs_fwdB), 32'(model_fwd(rte)));
      @(posedge clk);
      #1;
      hist.push_front('{wr: wr, we: we, ld: ld});
      void'(hist.pop_back());
      if (bt) begin
         if (fcnt < CNT_MAX) fcnt++;
      end else if (lu) begin
         if (scnt < CNT_MAX) scnt++;
      end
      chk("stallcnt", 32'(hz.stallcnt), 32'(scnt));
      chk("flushcnt", 32'(hz.flushcnt), 32'(fcnt));
   endtask

   // Assert reset between edges, zero inputs, check, release on a negedge.
   task automatic reset_phase();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      #1;
      model_reset();
      chk("rst_stallF",   32'(hz.stallF),   32'd0);
      chk("rst_stallD",   32'(hz.stallD),   32'd0);
      chk("rst_flushD",   32'(hz.flushD),   32'd0);
      chk("rst_flushE",   32'(hz.flushE),   32'd0);
      chk("rst_fwdAE",    32'(hz.fwdAE),    32'd0);
      chk("rst_fwdBE",    32'(hz.fwdBE),    32'd0);
      chk("rst_stallcnt", 32'(hz.stallcnt), 32'd0);
      chk("rst_flushcnt", 32'(hz.flushcnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      model_reset();
      #2;
      reset_phase();

      // M has priority over W; after a bubble the W copy is used.
      step(0, 0, 0, 0, 8, 1'b1, 1'b0, 1'b0);
      step(0, 0, 0, 0, 8, 1'b1, 1'b0, 1'b0);
      step(0, 0, 8, 0, 0, 1'b0, 1'b0, 1'b0);
      chk("mw_prio_fwdA", 32'(obs_fwdA), 32'd2);
      step(0, 0, 8, 0, 0, 1'b0, 1'b0, 1'b0);
      chk("w_after_bubble_fwdA", 32'(obs_fwdA), 32'd1);

      // Register 0 never forwards or stalls.
      step(0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
      step(0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
      chk("zero_fwdA", 32'(obs_fwdA), 32'd0);
      chk("zero_fwdB", 32'(obs_fwdB), 32'd0);
      step(0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
      chk("zero_no_stall", 32'(obs_stallF), 32'd0);

      // Load-use: one stall cycle, bubble, then forward from W.
      reset_phase();
      step(0, 5, 0, 0, 5, 1'b1, 1'b1, 1'b0);
      chk("lduse_stallF", 32'(obs_stallF), 32'd1);
      chk("lduse_flushE", 32'(obs_flushE), 32'd1);
      chk("lduse_cnt", 32'(hz.stallcnt), 32'd1);
      step(0, 5, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      chk("bubble_no_stall", 32'(obs_stallF), 32'd0);
      chk("bubble_no_mfwd", 32'(obs_fwdB), 32'd0);
      step(0, 0, 0, 5, 0, 1'b0, 1'b0, 1'b0);
      chk("lduse_fwdB_W", 32'(obs_fwdB), 32'd1);

      // Branch flush beats load-use.
      reset_phase();
      step(5, 0, 0, 0, 5, 1'b1, 1'b1, 1'b1);
      chk("br_flushD", 32'(obs_flushD), 32'd1);
      chk("br_stallF", 32'(obs_stallF), 32'd0);
      chk("br_flushcnt", 32'(hz.flushcnt), 32'd1);
      chk("br_stallcnt", 32'(hz.stallcnt), 32'd0);

      // Flush counter saturates at all-ones.
      reset_phase();
      for (int i = 0; i < 20; i++)
         step(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
      chk("flushcnt_sat", 32'(hz.flushcnt), 32'(CNT_MAX));

      // Reset in the middle of an active stall.
      reset_phase();
      step(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      drive(0, 7, 0, 0, 7, 1'b1, 1'b1, 1'b0);
      #2;
      chk("pre_rst_stall", 32'(hz.stallF), 32'd1);
      reset_phase();
      step(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      step(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_fwdA", 32'(obs_fwdA), 32'd0);
      chk("post_rst_fwdB", 32'(obs_fwdB), 32'd0);

      // Randomized traffic over a small register window to provoke matches.
      for (int i = 0; i < 400; i++) begin
         step(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)),
              bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0),
              bit'($urandom_range(0, 7) == 0));
         if (i == 200) reset_phase();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard and forwarding controller for the five-stage pipeline, sitting beside the decode-to-execute pipeline register. It reads D-stage source registers and E-stage control/destination fields, and keeps internal shadow copies of the M and W stage write-back fields. It drives stall/flush controls back into the fetch, decode and execute registers, and forwarding selects into the E-stage ALU operand muxes. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- `CNT_W`, default 16: width of the stall and flush event counters.
- `clk` in 1: rising-edge clock shared with all pipeline registers.
- `rst` in 1: asynchronous, active-high reset.
- `rsD` in 5: source register 1 of the instruction in D.
- `rtD` in 5: source register 2 of the instruction in D.
- `rsE` in 5: source register 1 of the instruction in E.
- `rtE` in 5: source register 2 of the instruction in E.
- `writeregE` in 5: destination register of the instruction in E.
- `rfweE` in 1: register-file write enable of the instruction in E.
- `mtorfselE` in 1: the instruction in E is a load (memory-to-RF).
- `branchtakenE` in 1: the branch in E resolved taken this cycle.
- `stallF` out 1: hold the PC.
- `stallD` out 1: hold the F-to-D register.
- `flushD` out 1: clear the F-to-D register on the next edge.
- `flushE` out 1: clear the D-to-E register on the next edge, inserting a bubble.
- `fwdAE` out 2: ALU operand A select. 00 = RF read, 01 = W result, 10 = M ALU result.
- `fwdBE` out 2: ALU operand B select, same encoding as `fwdAE`.
- `stallcnt` out CNT_W: number of load-use stall cycles, saturating.
- `flushcnt` out CNT_W: number of branch flush cycles, saturating.

## Operation
- **Shadow scoreboard.** Every edge shifts E fields into M, then M into W:
  - `writeregM/rfweM/mtorfselM` <= E values.
  - `writeregW/rfweW` <= M values.
  - A shadow write enable is effective only if the matching destination register is nonzero. Register 0 never matches.
- **Forwarding, operand A.** Computed combinationally.
  - If `rfweM`, `writeregM != 0`, `writeregM == rsE` and `!mtorfselM`, select 10.
  - Otherwise, if `rfweW`, `writeregW != 0` and `writeregW == rsE`, select 01.
  - Otherwise select 00.
  - M has priority over W.
- **Forwarding, operand B.** Same rule as operand A, using `rtE`.
- **Load-use hazard.** Defined as `lduse = mtorfselE & rfweE & writeregE != 0 & (writeregE == rsD | writeregE == rtD)`.
- **Branch flush.** Defined as `brflush = branchtakenE`.
- **Output priority.** Branch flush wins over load-use, because the D instruction is wrong-path.
  - `brflush`: `flushD=1`, `flushE=1`, `stallF=0`, `stallD=0`.
  - Else `lduse`: `stallF=1`, `stallD=1`, `flushE=1`, `flushD=0`.
  - Else all four are 0.
- **Counters.**
  - `stallcnt` increments on each edge where the load-use outputs are active, i.e. `lduse & !brflush`.
  - `flushcnt` increments on each edge where `brflush`.
  - Both hold at all-ones and never wrap.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and shadow state in the same cycle; they add zero latency.
- The shadow M fields reflect E one cycle later; the shadow W fields reflect E two cycles later.
- A load-use stall lasts exactly one cycle:
  - The next cycle E holds the bubble (`rfweE=0`), so `lduse` drops.
  - The load now sits in shadow M with `mtorfselM=1`, so no forward is taken from M.
  - One cycle later the load is in W and the consumer is in E, so the forward select is 01.
- Bubbles are inputs with `rfweE=0`; they shift through the scoreboard as non-writers.
- Reset, asynchronous and active-high, applies at any time including mid-stall:
  - All shadow fields go to 0.
  - Both counters go to 0.
  - All outputs evaluate to 0 when the inputs are 0.
  - The first edge after `rst` deasserts resumes normal shifting.
- Register number 0 is never a hazard or forward source, for any source register.

## Structure
- Shared package `pipe_pkg` holds:
  - The constants `FWD_RF=2'b00`, `FWD_W=2'b01`, `FWD_M=2'b10`.
  - `REG_ZERO=5'd0` and the register-index width `REGA_W=5`.
- One sub-module, `sat_counter` (parameter `W`; ports: clk, rst, inc, count), instantiated twice for `stallcnt` and `flushcnt`.
- The scoreboard shift, hazard detection and forward muxing live in the top module.

## Test plan
- **Reset.** Assert `rst` mid-run with a stall active. Required: all outputs 0, `stallcnt=0`, `flushcnt=0`. Two cycles after release, with all inputs 0, `fwdAE=fwdBE=00`.
- **M/W forwarding priority.** Drive E: `writeregE=8`, `rfweE=1` for 2 cycles, then E: `rsE=8`. Required: `fwdAE=10` (M wins over W). Then one bubble, then `rsE=8`: `fwdAE=01`.
- **Zero register.** Drive `writeregE=0`, `rfweE=1`, then `rsE=0`, `rtE=0`. Required: `fwdAE=fwdBE=00`. Drive `mtorfselE=1`, `rsD=0`: no stall.
- **Load-use stall.** Drive load E `writeregE=5` with `rtD=5`. Required: `stallF=stallD=flushE=1` for one cycle and `stallcnt=1`. Then bubble, then consumer in E with `rtE=5`: `fwdBE=01`.
- **Branch beats load-use.** Drive `branchtakenE=1` together with a load-use match. Required: `flushD=flushE=1`, `stallF=stallD=0`, `flushcnt` +1, `stallcnt` unchanged.
- **Counter saturation.** With `CNT_W=4`, hold `branchtakenE=1` for 20 cycles. Required: `flushcnt` stops at 15, no wrap.
